// File: rtl/fpu_sequencer_if.sv
// rtl/fpu_sequencer_if.sv - issue, FPU and writeback signal bundle for fpu_sequencer
interface fpu_sequencer_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] instr;
    logic [31:0] frs1;
    logic [31:0] frs2;
    logic [31:0] frs3;
    logic [31:0] xrs1;
    logic        fpu_enable;
    logic [31:0] fpu_instr;
    logic [31:0] fpu_rs1;
    logic [31:0] fpu_rs2;
    logic [31:0] fpu_rs3;
    logic        fpu_busy;
    logic [31:0] fpu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_to_fpr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic        timeout;

    // master is the sequencer; slave is the pipeline/FPU/register-file side
    modport master (
        input  issue_valid, instr, frs1, frs2, frs3, xrs1, fpu_busy, fpu_result, wb_ready,
        output issue_ready, fpu_enable, fpu_instr, fpu_rs1, fpu_rs2, fpu_rs3,
               wb_valid, wb_to_fpr, wb_rd, wb_data, illegal, timeout
    );

    modport slave (
        output issue_valid, instr, frs1, frs2, frs3, xrs1, fpu_busy, fpu_result, wb_ready,
        input  issue_ready, fpu_enable, fpu_instr, fpu_rs1, fpu_rs2, fpu_rs3,
               wb_valid, wb_to_fpr, wb_rd, wb_data, illegal, timeout
    );
endinterface

// File: rtl/fpu_sequencer.sv
// rtl/fpu_sequencer.sv - single-issue RV32F sequencer: issue, FPU wait with timeout, writeback
module fpu_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic            clk,
    input logic            reset,
    fpu_sequencer_if.master bus
);
    localparam logic [7:0] LAST_BUSY = 8'(TIMEOUT - 1);
    localparam logic [6:0] OP_FP     = 7'b1010011;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t      state, state_next;
    logic [31:0] instr_q, rs1_q, rs2_q, rs3_q, wb_data_q;
    logic [7:0]  wait_cnt;
    logic        illegal_q, timeout_q;
    logic        accept, legal, use_xrs1, executing, expire, int_dest;
    logic [4:0]  funct5_in, funct5_q;

    assign funct5_in = bus.instr[31:27];
    assign funct5_q  = instr_q[31:27];

    always_comb begin
        accept    = (state == IDLE) && bus.issue_valid;
        legal     = 1'b0;
        case (bus.instr[6:0])
            7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        // FMV.W.X and FCVT.S.W/WU take their source from the integer file
        use_xrs1  = (bus.instr[6:0] == OP_FP) && ((funct5_in == 5'b11110) || (funct5_in == 5'b11010));
        int_dest  = (instr_q[6:0] == OP_FP) &&
                    ((funct5_q == 5'b11100) || (funct5_q == 5'b10100) || (funct5_q == 5'b11000));
        executing = (state == ISSUE) || (state == WAIT);
        expire    = bus.fpu_busy && (wait_cnt == LAST_BUSY);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && legal) state_next = ISSUE;
            end
            ISSUE, WAIT: begin
                if (!bus.fpu_busy || expire) state_next = WB;
                else                         state_next = WAIT;
            end
            WB: begin
                if (bus.wb_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            instr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rs3_q     <= '0;
            wb_data_q <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            illegal_q <= accept && !legal;
            timeout_q <= executing && expire;
            if (accept) begin
                instr_q  <= bus.instr;
                rs1_q    <= use_xrs1 ? bus.xrs1 : bus.frs1;
                rs2_q    <= bus.frs2;
                rs3_q    <= bus.frs3;
                wait_cnt <= '0;
            end
            if (executing) begin
                if (!bus.fpu_busy)  wb_data_q <= bus.fpu_result;
                else if (expire)    wb_data_q <= '0;
                else                wait_cnt  <= wait_cnt + 8'd1;
            end
        end
    end

    assign bus.issue_ready = (state == IDLE);
    assign bus.fpu_enable  = executing;
    assign bus.fpu_instr   = instr_q;
    assign bus.fpu_rs1     = rs1_q;
    assign bus.fpu_rs2     = rs2_q;
    assign bus.fpu_rs3     = rs3_q;
    assign bus.wb_valid    = (state == WB);
    assign bus.wb_to_fpr   = (state == WB) && !int_dest;
    assign bus.wb_rd       = (state == WB) ? instr_q[11:7] : 5'd0;
    assign bus.wb_data     = wb_data_q;
    assign bus.illegal     = illegal_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_fpu_sequencer.sv
// tb/tb_fpu_sequencer.sv - directed and randomized checks of fpu_sequencer against a transaction model
module tb_fpu_sequencer;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpu_sequencer_if bus();
    fpu_sequencer #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_legal(input logic [31:0] i);
        return (i[6:0] == 7'h53) || (i[6:0] == 7'h43) || (i[6:0] == 7'h47) ||
               (i[6:0] == 7'h4B) || (i[6:0] == 7'h4F);
    endfunction

    function automatic logic m_int_dest(input logic [31:0] i);
        logic [4:0] f5;
        f5 = i[31:27];
        return (i[6:0] == 7'h53) && (f5 == 5'h1C || f5 == 5'h14 || f5 == 5'h18);
    endfunction

    function automatic logic m_from_x(input logic [31:0] i);
        logic [4:0] f5;
        f5 = i[31:27];
        return (i[6:0] == 7'h53) && (f5 == 5'h1E || f5 == 5'h1A);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 6))
            0, 1: begin
                i[6:0] = 7'h53;
                case ($urandom_range(0, 7))
                    0: i[31:27] = 5'h00;
                    1: i[31:27] = 5'h02;
                    2: i[31:27] = 5'h04;
                    3: i[31:27] = 5'h14;
                    4: i[31:27] = 5'h18;
                    5: i[31:27] = 5'h1A;
                    6: i[31:27] = 5'h1C;
                    default: i[31:27] = 5'h1E;
                endcase
            end
            2: i[6:0] = 7'h43;
            3: i[6:0] = 7'h47;
            4: i[6:0] = 7'h4B;
            5: i[6:0] = 7'h4F;
            default: if (m_legal(i)) i[6:0] = 7'h07;
        endcase
        return i;
    endfunction

    // One complete transaction; the FPU holds busy for busy_n enable cycles, then returns res
    task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] f1,
                          input logic [31:0] f2, input logic [31:0] f3, input logic [31:0] x1,
                          input int busy_n, input logic [31:0] res, input int stall);
        logic        exp_to;
        int          exp_en;
        int          n;
        logic [31:0] exp_data, exp_rs1;
        exp_to   = (busy_n >= TO);
        exp_en   = exp_to ? TO : busy_n + 1;
        exp_data = exp_to ? 32'd0 : res;
        exp_rs1  = m_from_x(ins) ? x1 : f1;

        check({tag, ":ready_idle"}, bus.issue_ready, 1);
        bus.issue_valid = 1'b1;
        bus.instr = ins; bus.frs1 = f1; bus.frs2 = f2; bus.frs3 = f3; bus.xrs1 = x1;
        bus.fpu_busy = 1'($urandom_range(0, 1));
        bus.fpu_result = $urandom;
        bus.wb_ready = 1'($urandom_range(0, 1));
        step();
        bus.issue_valid = 1'b0;
        bus.instr = $urandom; bus.frs1 = $urandom; bus.frs2 = $urandom;
        bus.frs3 = $urandom; bus.xrs1 = $urandom;

        if (!m_legal(ins)) begin
            check({tag, ":illegal_pulse"}, bus.illegal, 1);
            check({tag, ":illegal_no_en"}, bus.fpu_enable, 0);
            check({tag, ":illegal_ready"}, bus.issue_ready, 1);
            step();
            check({tag, ":illegal_once"}, bus.illegal, 0);
            check({tag, ":illegal_no_en2"}, bus.fpu_enable, 0);
            check({tag, ":illegal_no_wb"}, bus.wb_valid, 0);
            return;
        end
        check({tag, ":no_illegal"}, bus.illegal, 0);

        n = 0;
        while (bus.fpu_enable === 1'b1 && n < 300) begin
            bus.fpu_busy   = (n < busy_n);
            bus.fpu_result = (n < busy_n) ? $urandom : res;
            bus.wb_ready   = 1'($urandom_range(0, 1));
            check({tag, ":fpu_instr"}, bus.fpu_instr, ins);
            check({tag, ":fpu_rs1"}, bus.fpu_rs1, exp_rs1);
            check({tag, ":fpu_rs2"}, bus.fpu_rs2, f2);
            check({tag, ":fpu_rs3"}, bus.fpu_rs3, f3);
            check({tag, ":busy_not_ready"}, bus.issue_ready, 0);
            check({tag, ":busy_no_wb"}, bus.wb_valid, 0);
            step();
            n++;
        end
        check({tag, ":enable_cycles"}, n, exp_en);
        check({tag, ":timeout_pulse"}, bus.timeout, exp_to);

        for (int s = 0; s <= stall; s++) begin
            bus.wb_ready   = (s == stall);
            bus.fpu_busy   = 1'($urandom_range(0, 1));
            bus.fpu_result = $urandom;
            if (s > 0) check({tag, ":timeout_once"}, bus.timeout, 0);
            check({tag, ":wb_valid"}, bus.wb_valid, 1);
            check({tag, ":wb_data"}, bus.wb_data, exp_data);
            check({tag, ":wb_rd"}, bus.wb_rd, ins[11:7]);
            check({tag, ":wb_to_fpr"}, bus.wb_to_fpr, !m_int_dest(ins));
            check({tag, ":wb_not_ready"}, bus.issue_ready, 0);
            check({tag, ":wb_no_en"}, bus.fpu_enable, 0);
            step();
        end
        bus.wb_ready = 1'b0;
        check({tag, ":done_no_wb"}, bus.wb_valid, 0);
        check({tag, ":done_ready"}, bus.issue_ready, 1);
        check({tag, ":done_no_timeout"}, bus.timeout, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.issue_valid = 1'b0; bus.instr = '0; bus.frs1 = '0; bus.frs2 = '0;
        bus.frs3 = '0; bus.xrs1 = '0; bus.fpu_busy = 1'b0; bus.fpu_result = '0;
        bus.wb_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst:issue_ready", bus.issue_ready, 1);
        check("rst:fpu_enable", bus.fpu_enable, 0);
        check("rst:fpu_instr", bus.fpu_instr, 0);
        check("rst:fpu_rs1", bus.fpu_rs1, 0);
        check("rst:wb_valid", bus.wb_valid, 0);
        check("rst:wb_data", bus.wb_data, 0);
        check("rst:wb_rd", bus.wb_rd, 0);
        check("rst:wb_to_fpr", bus.wb_to_fpr, 0);
        check("rst:illegal", bus.illegal, 0);
        check("rst:timeout", bus.timeout, 0);

        run_op("fsgnj", 32'h202081D3, 32'h3F800000, 32'hC0000000, 32'h0, 32'h0, 0, 32'hBF800000, 0);
        run_op("feq", 32'hA020A2D3, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 0, 32'h00000001, 0);
        run_op("fmvwx", 32'hF00000D3, 32'h11111111, 32'h0, 32'h0, 32'h40490FDB, 0, 32'h40490FDB, 0);
        run_op("fmul", 32'h10208153, 32'h40000000, 32'h40400000, 32'h0, 32'h0, 3, 32'h40C00000, 0);
        run_op("tmo", 32'h10208153, 32'h40000000, 32'h40400000, 32'h0, 32'h0, 40, 32'h12345678, 1);
        run_op("edge7", 32'h10208153, 32'h1, 32'h2, 32'h3, 32'h0, TO - 1, 32'hCAFEF00D, 0);
        run_op("stall", 32'h0020F1C3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0, 1, 32'h40A00000, 5);
        run_op("illegal", 32'h00000013, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0);

        for (int k = 0; k < 40; k++) begin
            run_op($sformatf("rnd%0d", k), rand_instr(), $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, TO + 2), $urandom, $urandom_range(0, 3));
        end

        // Reset while waiting: operation is dropped, and an instruction offered under reset is not taken
        bus.issue_valid = 1'b1; bus.instr = 32'h10208153; bus.frs1 = 32'h1; bus.frs2 = 32'h2;
        step();
        bus.issue_valid = 1'b0; bus.fpu_busy = 1'b1; bus.wb_ready = 1'b1;
        step();
        step();
        check("rstw:in_wait", bus.fpu_enable, 1);
        reset = 1'b1; bus.issue_valid = 1'b1;
        step();
        reset = 1'b0; bus.issue_valid = 1'b0; bus.fpu_busy = 1'b0;
        check("rstw:fpu_enable", bus.fpu_enable, 0);
        check("rstw:issue_ready", bus.issue_ready, 1);
        check("rstw:wb_valid", bus.wb_valid, 0);
        check("rstw:timeout", bus.timeout, 0);
        check("rstw:illegal", bus.illegal, 0);
        step();
        check("rstw:not_accepted", bus.fpu_enable, 0);
        check("rstw:still_no_wb", bus.wb_valid, 0);
        step();
        check("rstw:idle_ready", bus.issue_ready, 1);
        bus.wb_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fpu_sequencer.md
FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 64, maximum cycles spent waiting on fpuBusy_i before abort (range 2..255).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 issueValid_i  input  1  pipeline presents an FP instruction.
REQ-005 issueReady_o  output  1  sequencer accepts the instruction this cycle.
REQ-006 instr_i  input  32  raw RV32F instruction word.
REQ-007 frs1_i, frs2_i, frs3_i  input  32 each  FP register-file read data.
REQ-008 xrs1_i  input  32  integer register-file read data for rs1.
REQ-009 fpuEnable_o  output  1  request to the FPU execution unit.
REQ-010 fpuInstr_o  output  32  instruction word driven to the FPU.
REQ-011 fpuRs1_o, fpuRs2_o, fpuRs3_o  output  32 each  FPU operands.
REQ-012 fpuBusy_i  input  1  FPU still computing; result invalid while high.
REQ-013 fpuResult_i  input  32  FPU result; valid in any cycle with fpuEnable_o=1 and fpuBusy_i=0.
REQ-014 wbValid_o  output  1  writeback request.
REQ-015 wbReady_i  input  1  register file accepts writeback.
REQ-016 wbToFpr_o  output  1  1 = write FP register file, 0 = integer register file.
REQ-017 wbRd_o  output  5  destination register, instr[11:7].
REQ-018 wbData_o  output  32  writeback data.
REQ-019 illegal_o  output  1  one-cycle pulse: unsupported opcode accepted.
REQ-020 timeout_o  output  1  one-cycle pulse: FPU wait aborted.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, WB; issueReady_o SHALL be 1 only in IDLE.
REQ-022 IDLE: on issueValid_i=1, latch instr_i and operands; legal opcode -> ISSUE; otherwise pulse illegal_o next cycle, stay IDLE.
REQ-023 Legal opcodes instr[6:0]: 1010011, 1000011, 1000111, 1001011, 1001111; all others are illegal.
REQ-024 fpuRs1_o SHALL be latched xrs1_i for FMV.W.X (funct5 11110) and FCVT.S.W/WU (funct5 11010), else latched frs1_i; fpuRs2_o/fpuRs3_o = latched frs2_i/frs3_i.
REQ-025 fpuEnable_o=1 in ISSUE and WAIT only; fpuInstr_o and fpuRs*_o SHALL hold constant from ISSUE entry until WB entry.
REQ-026 ISSUE/WAIT: fpuBusy_i=0 -> capture fpuResult_i into wbData_o, go WB; fpuBusy_i=1 -> WAIT (from ISSUE) or stay WAIT.
REQ-027 8-bit wait counter cleared on ISSUE entry, incremented each ISSUE/WAIT cycle with fpuBusy_i=1; reaching TIMEOUT -> WB with wbData_o=0, timeout_o pulsed one cycle.
REQ-028 Minimum latency: accept at edge N, ISSUE cycle N+1, wbValid_o=1 in cycle N+2.
REQ-029 wbToFpr_o=0 for FMV.X.W (funct5 11100, funct3[0]=0), FCLASS (11100, funct3[0]=1), FEQ/FLT/FLE (10100), FCVT.W.S/WU.S (11000); 1 for all other legal instructions including FMA forms.
REQ-030 WB: wbValid_o=1, wbRd_o/wbToFpr_o/wbData_o stable until wbReady_i=1; on wbValid_o&wbReady_i go IDLE.
REQ-031 No back-to-back overlap: next instruction accepted no earlier than the cycle after the WB handshake.
REQ-032 fpuBusy_i and fpuResult_i SHALL be ignored in IDLE and WB.
REQ-033 wbReady_i held high before WB SHALL have no effect.

Reset
REQ-034 reset_i=1 at an edge: state IDLE, counter 0, all outputs 0 except issueReady_o=1 in the following cycle.
REQ-035 Reset in ISSUE/WAIT/WB SHALL abandon the operation: no wbValid_o, illegal_o, or timeout_o pulse for it; fpuEnable_o=0 the cycle after.
REQ-036 reset_i overrides simultaneous issueValid_i; the instruction is not accepted.

Verification
REQ-037 FSGNJ.S f3,f1,f2 (0x202081D3), frs1=0x3F800000, frs2=0xC0000000, busy low -> wbValid_o at cycle N+2, wbData_o=0xBF800000, wbToFpr_o=1, wbRd_o=3.
REQ-038 FEQ.S x5,f1,f2 (0xA020A2D3), FPU result 0x00000001 -> wbToFpr_o=0, wbRd_o=5, wbData_o=1; FMV.W.X with xrs1_i=0x40490FDB -> fpuRs1_o=0x40490FDB.
REQ-039 FMUL.S with fpuBusy_i high 3 cycles after ISSUE then result 0x40C00000 -> fpuEnable_o high exactly 4 cycles, operands constant, wbData_o=0x40C00000.
REQ-040 fpuBusy_i stuck high, TIMEOUT=8 -> after 8 busy cycles timeout_o single pulse, wbValid_o=1, wbData_o=0.
REQ-041 wbReady_i low 5 cycles in WB -> wbValid_o and data stable 6 cycles, issueReady_o=0 throughout, IDLE after handshake.
REQ-042 reset_i in WAIT and, separately, instr_i=0x00000013 (illegal) -> first: IDLE, no writeback; second: illegal_o one pulse, fpuEnable_o never asserted.
